// File: rtl/tlb_pkg.sv
// Shared TLB field widths, entry layout and half-page select helper.
package tlb_pkg;

  localparam int VPN2_W         = 19;
  localparam int ASID_W         = 8;
  localparam int PFN_W          = 20;
  localparam int C_W            = 3;
  localparam int TLBNUM_DEFAULT = 16;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } tlb_page_t;

  // Pick the even or odd page half of an entry.
  function automatic tlb_page_t sel_page(input tlb_entry_t e, input logic odd);
    tlb_page_t p;
    if (odd) begin
      p = '{pfn: e.pfn1, c: e.c1, d: e.d1, v: e.v1};
    end else begin
      p = '{pfn: e.pfn0, c: e.c0, d: e.d0, v: e.v0};
    end
    return p;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Per-entry comparator: VPN2 must be equal and the entry must be global
// or carry the searched ASID.
import tlb_pkg::*;

module tlb_match (
  input  logic [VPN2_W-1:0] ent_vpn2,
  input  logic [ASID_W-1:0] ent_asid,
  input  logic              ent_g,
  input  logic [VPN2_W-1:0] s_vpn2,
  input  logic [ASID_W-1:0] s_asid,
  output logic              match
);

  assign match = (ent_vpn2 == s_vpn2) && (ent_g || (ent_asid == s_asid));

endmodule

// File: rtl/tlb.sv
// Joint TLB: TLBNUM dual-page entries, two combinational search ports,
// one write port and a registered read port.
// Optional feature macro: TLB_MULTIHIT_EN adds s0_multihit/s1_multihit.
import tlb_pkg::*;

module tlb #(
  parameter int TLBNUM = TLBNUM_DEFAULT,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDXW-1:0]   s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDXW-1:0]   s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,
`ifdef TLB_MULTIHIT_EN
  output logic              s0_multihit,
  output logic              s1_multihit,
`endif
  input  logic              we,
  input  logic [IDXW-1:0]   w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  input  logic              re,
  input  logic [IDXW-1:0]   r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1,
  output logic              r_valid
);

  tlb_entry_t        entry_q [TLBNUM];
  tlb_entry_t        w_entry_s;
  tlb_entry_t        r_entry_q;
  logic              r_valid_q;
  logic [TLBNUM-1:0] s0_match_s, s1_match_s;
  logic [IDXW-1:0]   s0_idx_s, s1_idx_s;
  tlb_page_t         s0_page_s, s1_page_s;

  assign w_entry_s = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                       pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // Entry array: cleared by reset, otherwise written on we.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        entry_q[i] <= '0;
      end
    end else if (we) begin
      entry_q[w_index] <= w_entry_s;
    end
  end

  // Read port samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry_q <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= re;
      if (re) begin
        r_entry_q <= entry_q[r_index];
      end else begin
        r_entry_q <= r_entry_q;
      end
    end
  end

  for (genvar i = 0; i < TLBNUM; i++) begin : g_match
    tlb_match u_m0 (
      .ent_vpn2 (entry_q[i].vpn2),
      .ent_asid (entry_q[i].asid),
      .ent_g    (entry_q[i].g),
      .s_vpn2   (s0_vpn2),
      .s_asid   (s0_asid),
      .match    (s0_match_s[i])
    );
    tlb_match u_m1 (
      .ent_vpn2 (entry_q[i].vpn2),
      .ent_asid (entry_q[i].asid),
      .ent_g    (entry_q[i].g),
      .s_vpn2   (s1_vpn2),
      .s_asid   (s1_asid),
      .match    (s1_match_s[i])
    );
  end

  // Priority encoders: scanning downward leaves the lowest matching index.
  always_comb begin
    s0_idx_s = '0;
    s1_idx_s = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s0_match_s[i]) begin
        s0_idx_s = IDXW'(i);
      end else begin
        s0_idx_s = s0_idx_s;
      end
      if (s1_match_s[i]) begin
        s1_idx_s = IDXW'(i);
      end else begin
        s1_idx_s = s1_idx_s;
      end
    end
  end

  // Half-page select, forced to zero on a miss.
  always_comb begin
    s0_page_s = '0;
    s1_page_s = '0;
    if (|s0_match_s) begin
      s0_page_s = sel_page(entry_q[s0_idx_s], s0_odd_page);
    end else begin
      s0_page_s = '0;
    end
    if (|s1_match_s) begin
      s1_page_s = sel_page(entry_q[s1_idx_s], s1_odd_page);
    end else begin
      s1_page_s = '0;
    end
  end

  assign s0_found = |s0_match_s;
  assign s0_index = s0_idx_s;
  assign s0_pfn   = s0_page_s.pfn;
  assign s0_c     = s0_page_s.c;
  assign s0_d     = s0_page_s.d;
  assign s0_v     = s0_page_s.v;
  assign s1_found = |s1_match_s;
  assign s1_index = s1_idx_s;
  assign s1_pfn   = s1_page_s.pfn;
  assign s1_c     = s1_page_s.c;
  assign s1_d     = s1_page_s.d;
  assign s1_v     = s1_page_s.v;

`ifdef TLB_MULTIHIT_EN
  // Clearing the lowest set bit leaves something only when two or more match.
  assign s0_multihit = |(s0_match_s & (s0_match_s - TLBNUM'(1)));
  assign s1_multihit = |(s1_match_s & (s1_match_s - TLBNUM'(1)));
`endif

  assign r_vpn2  = r_entry_q.vpn2;
  assign r_asid  = r_entry_q.asid;
  assign r_g     = r_entry_q.g;
  assign r_pfn0  = r_entry_q.pfn0;
  assign r_c0    = r_entry_q.c0;
  assign r_d0    = r_entry_q.d0;
  assign r_v0    = r_entry_q.v0;
  assign r_pfn1  = r_entry_q.pfn1;
  assign r_c1    = r_entry_q.c1;
  assign r_d1    = r_entry_q.d1;
  assign r_v1    = r_entry_q.v1;
  assign r_valid = r_valid_q;

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios followed by random traffic,
// all compared against an array-based reference model of the TLB.
module tb_tlb;

  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
`ifdef TLB_MULTIHIT_EN
  logic        s0_multihit, s1_multihit;
`endif
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic        re;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic        r_valid;

  tlb #(.TLBNUM(N)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
`ifdef TLB_MULTIHIT_EN
    .s0_multihit(s0_multihit), .s1_multihit(s1_multihit),
`endif
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .re(re), .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .r_valid(r_valid)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Reference model state.
  logic [18:0] m_vpn2 [N];
  logic [7:0]  m_asid [N];
  logic        m_g    [N];
  logic [19:0] m_pfn0 [N], m_pfn1 [N];
  logic [2:0]  m_c0   [N], m_c1   [N];
  logic        m_d0   [N], m_v0 [N], m_d1 [N], m_v1 [N];
  logic [77:0] exp_rd;
  logic        exp_rv;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [77:0] entry_bits(input int i);
    return {m_vpn2[i], m_asid[i], m_g[i], m_pfn0[i], m_c0[i], m_d0[i], m_v0[i],
            m_pfn1[i], m_c1[i], m_d1[i], m_v1[i]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
      m_pfn0[i] = '0; m_c0[i] = '0; m_d0[i] = 1'b0; m_v0[i] = 1'b0;
      m_pfn1[i] = '0; m_c1[i] = '0; m_d1[i] = 1'b0; m_v1[i] = 1'b0;
    end
  endtask

  task automatic model_search(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                              output logic f, output logic [3:0] idx, output logic [19:0] pfn,
                              output logic [2:0] c, output logic d, output logic v, output int cnt);
    f = 1'b0; idx = '0; pfn = '0; c = '0; d = 1'b0; v = 1'b0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) begin
        cnt++;
        if (!f) begin
          f = 1'b1;
          idx = 4'(i);
          pfn = odd ? m_pfn1[i] : m_pfn0[i];
          c   = odd ? m_c1[i]   : m_c0[i];
          d   = odd ? m_d1[i]   : m_d0[i];
          v   = odd ? m_v1[i]   : m_v0[i];
        end
      end
    end
  endtask

  task automatic check_port(input string p, input logic [18:0] vpn2, input logic odd,
                            input logic [7:0] asid, input logic af, input logic [3:0] aidx,
                            input logic [19:0] apfn, input logic [2:0] ac, input logic ad,
                            input logic av, input logic amh);
    logic f, d, v; logic [3:0] idx; logic [19:0] pfn; logic [2:0] c; int cnt;
    model_search(vpn2, odd, asid, f, idx, pfn, c, d, v, cnt);
    check({p, "_found"}, af, f);
    check({p, "_index"}, aidx, idx);
    check({p, "_pfn"}, apfn, pfn);
    check({p, "_cdv"}, {ac, ad, av}, {c, d, v});
`ifdef TLB_MULTIHIT_EN
    check({p, "_multihit"}, amh, cnt >= 2);
`endif
  endtask

  // One cycle: check searches now, let the edge happen, then check reads.
  task automatic step();
    logic [77:0] next_rd;
    logic        next_rv;
    logic        mh0, mh1;
    #1;
`ifdef TLB_MULTIHIT_EN
    mh0 = s0_multihit; mh1 = s1_multihit;
`else
    mh0 = 1'b0; mh1 = 1'b0;
`endif
    check_port("s0", s0_vpn2, s0_odd_page, s0_asid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, mh0);
    check_port("s1", s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, mh1);
    if (reset) begin
      next_rd = '0; next_rv = 1'b0;
    end else if (re) begin
      next_rd = entry_bits(int'(r_index)); next_rv = 1'b1;
    end else begin
      next_rd = exp_rd; next_rv = 1'b0;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else if (we) begin
      m_vpn2[w_index] = w_vpn2; m_asid[w_index] = w_asid; m_g[w_index] = w_g;
      m_pfn0[w_index] = w_pfn0; m_c0[w_index] = w_c0; m_d0[w_index] = w_d0; m_v0[w_index] = w_v0;
      m_pfn1[w_index] = w_pfn1; m_c1[w_index] = w_c1; m_d1[w_index] = w_d1; m_v1[w_index] = w_v1;
    end
    exp_rd = next_rd;
    exp_rv = next_rv;
    check("r_valid", r_valid, exp_rv);
    check("r_data", {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}, exp_rd);
    @(negedge clk);
  endtask

  task automatic set_w(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                       input logic g, input logic [19:0] pfn0, input logic d0, input logic v0,
                       input logic [19:0] pfn1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = 3'd3; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = 3'd2; w_d1 = 1'b0; w_v1 = v1;
  endtask

  task automatic search(input logic [18:0] vpn2, input logic [7:0] asid);
    s0_vpn2 = vpn2; s0_asid = asid; s0_odd_page = 1'b0;
    s1_vpn2 = vpn2; s1_asid = asid; s1_odd_page = 1'b1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; r_index = '0;
    w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    search(19'h0, 8'h0);
    model_clear();
    exp_rd = '0; exp_rv = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;

    // After reset every entry matches vpn2=0/asid=0.
    #1;
    check("rst_found", s0_found, 1'b1);
    check("rst_index", s0_index, 4'd0);
    check("rst_v", s0_v, 1'b0);
    step();

    // Write idx 5 and look it up through both halves.
    set_w(4'd5, 19'h00123, 8'h0A, 1'b0, 20'h00456, 1'b1, 1'b1, 20'h00789, 1'b0);
    step();
    we = 1'b0;
    search(19'h00123, 8'h0A);
    #1;
    check("e5_found", s0_found, 1'b1);
    check("e5_index", s0_index, 4'd5);
    check("e5_even", {s0_pfn, s0_v, s0_d}, {20'h00456, 1'b1, 1'b1});
    check("e5_odd", {s1_pfn, s1_v}, {20'h00789, 1'b0});
    step();

    // ASID mismatch misses until the entry is made global.
    search(19'h00123, 8'h0B);
    #1;
    check("asid_miss", s0_found, 1'b0);
    set_w(4'd5, 19'h00123, 8'h0A, 1'b1, 20'h00456, 1'b1, 1'b1, 20'h00789, 1'b0);
    step();
    we = 1'b0;
    #1;
    check("global_hit", s0_found, 1'b1);
    step();

    // Duplicate entries: lowest index wins.
    set_w(4'd3, 19'h00ABC, 8'h01, 1'b0, 20'h00111, 1'b0, 1'b1, 20'h0, 1'b0);
    step();
    set_w(4'd9, 19'h00ABC, 8'h01, 1'b0, 20'h00222, 1'b0, 1'b1, 20'h0, 1'b0);
    step();
    we = 1'b0;
    search(19'h00ABC, 8'h01);
    #1;
    check("dup_index", s0_index, 4'd3);
    check("dup_pfn", s0_pfn, 20'h00111);
`ifdef TLB_MULTIHIT_EN
    check("dup_multihit", s0_multihit, 1'b1);
`endif
    step();

    // Read-before-write on the same index.
    re = 1'b1; r_index = 4'd5;
    set_w(4'd5, 19'h00123, 8'h0A, 1'b1, 20'h0AAAA, 1'b1, 1'b1, 20'h00789, 1'b0);
    step();
    check("rbw_old", r_pfn0, 20'h00456);
    check("rbw_valid", r_valid, 1'b1);
    we = 1'b0;
    step();
    check("rd_new", r_pfn0, 20'h0AAAA);
    re = 1'b0;
    step();
    check("rd_hold_pfn", r_pfn0, 20'h0AAAA);
    check("rd_pulse", r_valid, 1'b0);

    // Reset wins over a simultaneous write and read.
    reset = 1'b1; re = 1'b1; r_index = 4'd5;
    set_w(4'd2, 19'h00555, 8'h00, 1'b1, 20'h00333, 1'b1, 1'b1, 20'h0, 1'b0);
    step();
    reset = 1'b0; we = 1'b0; re = 1'b0;
    search(19'h00555, 8'h00);
    #1;
    check("rst_we_miss", s0_found, 1'b0);
    check("rst_re_valid", r_valid, 1'b0);
    step();

    // Random traffic over a small VPN2/ASID pool so hits and duplicates occur.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 2) == 0);
      r_index = 4'($urandom_range(0, N - 1));
      w_index = 4'($urandom_range(0, N - 1));
      w_vpn2 = 19'($urandom_range(0, 3));
      w_asid = 8'($urandom_range(0, 3));
      w_g = ($urandom_range(0, 3) == 0);
      w_pfn0 = 20'($urandom); w_c0 = 3'($urandom); w_d0 = 1'($urandom); w_v0 = 1'($urandom);
      w_pfn1 = 20'($urandom); w_c1 = 3'($urandom); w_d1 = 1'($urandom); w_v1 = 1'($urandom);
      s0_vpn2 = 19'($urandom_range(0, 3)); s0_asid = 8'($urandom_range(0, 3));
      s0_odd_page = 1'($urandom);
      s1_vpn2 = 19'($urandom_range(0, 3)); s1_asid = 8'($urandom_range(0, 3));
      s1_odd_page = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
